// File: rtl/cmd_frame_rx.sv
// Three-byte command frame receiver (opcode, data high, data low) with a one-byte response transmitter.
// Optional inter-byte timeout is enabled by defining CMD_TIMEOUT_EN (window set by TIMEOUT_CYC).
module cmd_frame_rx #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic        cmd_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  input  logic        clr_cmd_rdy,
  input  logic [7:0]  resp,
  input  logic        send_resp,
  output logic [7:0]  tx_data,
  output logic        trmt,
  input  logic        tx_done,
  output logic        resp_sent
);

  typedef enum logic [1:0] {
    WAIT_CMD = 2'd0,
    WAIT_DHI = 2'd1,
    WAIT_DLO = 2'd2
  } rx_state_t;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_t;

  rx_state_t   rx_state_q;
  tx_state_t   tx_state_q;
  logic [7:0]  cmd_sh_q;
  logic [7:0]  dhi_sh_q;
  logic [7:0]  cmd_q;
  logic [15:0] data_q;
  logic        cmd_rdy_q;
  logic [7:0]  tx_data_q;
  logic        trmt_q;
  logic        resp_sent_q;
  logic        timeout_s;

  // Combinational so the receiver drops rx_rdy on the same edge that captures the byte.
  assign clr_rx_rdy = rx_rdy & ~rst;

`ifdef CMD_TIMEOUT_EN
  logic [15:0] tmo_cnt_q;
  logic [15:0] tmo_cnt_d;

  always_comb begin
    tmo_cnt_d = tmo_cnt_q + 16'd1;
    if (rx_rdy || (rx_state_q == WAIT_CMD)) begin
      tmo_cnt_d = 16'd0;
    end else begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
  end

  // Idle-cycle counter while a frame is partially received.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= 16'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign timeout_s = (rx_state_q != WAIT_CMD) && !rx_rdy &&
                     (tmo_cnt_q == (TIMEOUT_CYC - 16'd1));
`else
  logic unused_tmo_s;
  assign unused_tmo_s = ^TIMEOUT_CYC;
  assign timeout_s    = 1'b0;
`endif

  // Receive FSM: shadow the first two bytes, publish the frame on the third.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= WAIT_CMD;
      cmd_sh_q   <= 8'h00;
      dhi_sh_q   <= 8'h00;
      cmd_q      <= 8'h00;
      data_q     <= 16'h0000;
      cmd_rdy_q  <= 1'b0;
    end else begin
      if (clr_cmd_rdy) begin
        cmd_rdy_q <= 1'b0;
      end
      case (rx_state_q)
        WAIT_CMD: begin
          if (rx_rdy) begin
            cmd_sh_q   <= rx_data;
            cmd_rdy_q  <= 1'b0;
            rx_state_q <= WAIT_DHI;
          end
        end
        WAIT_DHI: begin
          if (rx_rdy) begin
            dhi_sh_q   <= rx_data;
            rx_state_q <= WAIT_DLO;
          end else if (timeout_s) begin
            rx_state_q <= WAIT_CMD;
          end
        end
        WAIT_DLO: begin
          // Completion is written last so it overrides a same-cycle clr_cmd_rdy.
          if (rx_rdy) begin
            cmd_q      <= cmd_sh_q;
            data_q     <= {dhi_sh_q, rx_data};
            cmd_rdy_q  <= 1'b1;
            rx_state_q <= WAIT_CMD;
          end else if (timeout_s) begin
            rx_state_q <= WAIT_CMD;
          end
        end
        default: begin
          rx_state_q <= WAIT_CMD;
        end
      endcase
    end
  end

  // Transmit FSM: one response in flight at a time, extra requests dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q  <= TX_IDLE;
      tx_data_q   <= 8'h00;
      trmt_q      <= 1'b0;
      resp_sent_q <= 1'b0;
    end else begin
      trmt_q      <= 1'b0;
      resp_sent_q <= 1'b0;
      case (tx_state_q)
        TX_IDLE: begin
          if (send_resp) begin
            tx_data_q  <= resp;
            trmt_q     <= 1'b1;
            tx_state_q <= TX_BUSY;
          end
        end
        TX_BUSY: begin
          if (tx_done) begin
            resp_sent_q <= 1'b1;
            tx_state_q  <= TX_IDLE;
          end
        end
        default: begin
          tx_state_q <= TX_IDLE;
        end
      endcase
    end
  end

  assign cmd_rdy   = cmd_rdy_q;
  assign cmd       = cmd_q;
  assign data      = data_q;
  assign tx_data   = tx_data_q;
  assign trmt      = trmt_q;
  assign resp_sent = resp_sent_q;

endmodule

// File: doc/cmd_frame_rx.md
CMD_FRAME_RX -- requirements
Module: cmd_frame_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16'd50000, meaning the inter-byte timeout in clk cycles (used only with CMD_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  system clock; all logic is rising-edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL have port rx_rdy  input  1  UART receiver holds a valid byte.
REQ-005 SHALL have port rx_data  input  8  received byte.
REQ-006 SHALL have port clr_rx_rdy  output  1  one-cycle pulse acknowledging rx_data.
REQ-007 SHALL have port cmd_rdy  output  1  a complete command frame is held.
REQ-008 SHALL have port cmd  output  8  opcode of the held frame.
REQ-009 SHALL have port data  output  16  payload of the held frame, {byte2, byte3}.
REQ-010 SHALL have port clr_cmd_rdy  input  1  consumer (command processor) releases the frame.
REQ-011 SHALL have port resp  input  8  response byte to transmit (e.g. 8'hA5 positive ack).
REQ-012 SHALL have port send_resp  input  1  request to transmit resp.
REQ-013 SHALL have port tx_data  output  8  byte to the UART transmitter.
REQ-014 SHALL have port trmt  output  1  one-cycle transmit start pulse.
REQ-015 SHALL have port tx_done  input  1  UART transmitter finished its byte.
REQ-016 SHALL have port resp_sent  output  1  one-cycle pulse when the response is fully sent.

Function
REQ-017 Receive FSM SHALL have states WAIT_CMD, WAIT_DHI, WAIT_DLO.
REQ-018 In each state, rx_rdy high SHALL capture rx_data, pulse clr_rx_rdy in the same cycle, and advance WAIT_CMD->WAIT_DHI->WAIT_DLO->WAIT_CMD.
REQ-019 Bytes SHALL be captured into shadow registers; cmd/data SHALL update only when the third byte is accepted, and SHALL stay stable while cmd_rdy is high.
REQ-020 cmd_rdy SHALL rise in the cycle after the third byte is accepted, concurrently with the cmd/data update.
REQ-021 cmd_rdy SHALL clear on clr_cmd_rdy, or when the first byte of a new frame is accepted.
REQ-022 Frame completion and clr_cmd_rdy in the same cycle: completion SHALL win, and cmd_rdy SHALL end high.
REQ-023 A frame completing while cmd_rdy is still high SHALL overwrite cmd/data; cmd_rdy SHALL stay high.
REQ-024 Transmit side SHALL have states TX_IDLE and TX_BUSY.
REQ-025 In TX_IDLE, send_resp SHALL latch resp into tx_data, pulse trmt for exactly one cycle, and enter TX_BUSY.
REQ-026 In TX_BUSY, send_resp SHALL be ignored; tx_done SHALL pulse resp_sent for one cycle and return to TX_IDLE.
REQ-027 tx_data SHALL hold its value until the next accepted send_resp.
REQ-028 Receive and transmit FSMs SHALL operate independently; simultaneous activity SHALL NOT stall either.

Reset
REQ-029 On rst, the receive FSM SHALL go to WAIT_CMD and the transmit FSM to TX_IDLE.
REQ-030 On rst, cmd_rdy, clr_rx_rdy, trmt and resp_sent SHALL be 0; cmd, data, tx_data and the shadow registers SHALL be 0.
REQ-031 rst mid-frame or mid-transmit SHALL discard the partial frame, drop the pending response, and produce no resp_sent.

Configuration
REQ-032 With macro CMD_TIMEOUT_EN defined, a timeout SHALL apply in WAIT_DHI and WAIT_DLO.
- A counter SHALL clear on every accepted byte.
- After TIMEOUT_CYC cycles with no rx_rdy, the FSM SHALL return to WAIT_CMD and discard the partial frame.
- cmd_rdy and cmd/data SHALL be unaffected by the timeout.
REQ-033 Without CMD_TIMEOUT_EN, no counter SHALL be synthesized, and a partial frame SHALL wait indefinitely.

Verification
REQ-034 Bytes 05, 00, 20 with gaps -> cmd_rdy=1, cmd=8'h05, data=16'h0020; one clr_rx_rdy pulse per byte.
REQ-035 cmd_rdy=1, then clr_cmd_rdy asserted in the same cycle as completion of frame 06,12,34 -> cmd_rdy stays 1, cmd=8'h06, data=16'h1234.
REQ-036 send_resp with resp=8'hA5, second send_resp with 8'h55 while busy, then tx_done -> tx_data=8'hA5, exactly one trmt and one resp_sent.
REQ-037 rst after byte 05 only, then 02,AB,CD -> cmd=8'h02, data=16'hABCD, no stale byte.
REQ-038 CMD_TIMEOUT_EN with TIMEOUT_CYC=100: bytes 05,00, then 150 idle cycles, then 07,11,22 -> cmd=8'h07, data=16'h1122; without the macro -> cmd=8'h05, data=16'h0007.
